// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Purpose:
//   Owns the single register-file write port and shares it between the core
//   writeback path (req0) and the debug/loader path (req1). Also contains a
//   clear sequencer that zeroes x1..x(NumRegs-1), one register per cycle.
//
// Optional feature (compile-time macro):
//   REGFILE_ARB_RR_EN - when defined, a tie between req0 and req1 is resolved
//                       round-robin (the requester not granted last wins).
//                       When undefined, req0 always has priority.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   req0_valid/addr/data_i writeback write request
//   req0_ready_o           writeback request accepted this cycle (comb)
//   req1_valid/addr/data_i debug/loader write request
//   req1_ready_o           debug request accepted this cycle (comb)
//   clr_start_i            clear-sequence start pulse
//   clr_busy_o             clear sequence in progress (registered)
//   clr_done_o             one-cycle pulse at end of clear (registered)
//   rf_wr_en_o             regfile write enable (registered)
//   rf_rd_addr_o           regfile write address (registered, holds)
//   rf_rd_data_o           regfile write data (registered, holds)
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int NumRegs      = 32,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = $clog2(NumRegs)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req0_valid_i,
    input  logic [AddressWidth-1:0] req0_addr_i,
    input  logic [DataWidth-1:0]    req0_data_i,
    output logic                    req0_ready_o,
    input  logic                    req1_valid_i,
    input  logic [AddressWidth-1:0] req1_addr_i,
    input  logic [DataWidth-1:0]    req1_data_i,
    output logic                    req1_ready_o,
    input  logic                    clr_start_i,
    output logic                    clr_busy_o,
    output logic                    clr_done_o,
    output logic                    rf_wr_en_o,
    output logic [AddressWidth-1:0] rf_rd_addr_o,
    output logic [DataWidth-1:0]    rf_rd_data_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [AddressWidth-1:0] ADDR_ZERO = {AddressWidth{1'b0}};
    localparam logic [AddressWidth-1:0] ADDR_ONE  = AddressWidth'(1);
    localparam logic [AddressWidth-1:0] ADDR_LAST = AddressWidth'(NumRegs - 1);
    localparam logic [DataWidth-1:0]    DATA_ZERO = {DataWidth{1'b0}};

    logic [0:0]              state_q,    state_d;
    logic [AddressWidth-1:0] clr_addr_q, clr_addr_d;
    logic                    busy_q,     busy_d;
    logic                    done_q,     done_d;
    logic                    wr_en_q,    wr_en_d;
    logic [AddressWidth-1:0] wr_addr_q,  wr_addr_d;
    logic [DataWidth-1:0]    wr_data_q,  wr_data_d;
`ifdef REGFILE_ARB_RR_EN
    // 1 = req1 was granted last, so req0 wins the next tie.
    logic                    rr_last_q,  rr_last_d;
`endif

    // Grant decode: readies only while idle and no clear is being requested.
    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        if ((state_q == ST_IDLE) && !clr_start_i) begin
`ifdef REGFILE_ARB_RR_EN
            if (req0_valid_i && req1_valid_i) begin
                if (rr_last_q) begin
                    req0_ready_o = 1'b1;
                end else begin
                    req1_ready_o = 1'b1;
                end
            end else begin
                req0_ready_o = req0_valid_i;
                req1_ready_o = req1_valid_i;
            end
`else
            req0_ready_o = req0_valid_i;
            req1_ready_o = req1_valid_i & ~req0_valid_i;
`endif
        end else begin
            req0_ready_o = 1'b0;
            req1_ready_o = 1'b0;
        end
    end

    // Next-state logic for the sequencer and the registered write port.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef REGFILE_ARB_RR_EN
        rr_last_d  = rr_last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (clr_start_i) begin
                    state_d    = ST_CLEAR;
                    busy_d     = 1'b1;
                    clr_addr_d = ADDR_ONE;
                end else if (req0_ready_o) begin
`ifdef REGFILE_ARB_RR_EN
                    rr_last_d = 1'b0;
`endif
                    // Writes to x0 are accepted but never reach the file.
                    if (req0_addr_i != ADDR_ZERO) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = req0_addr_i;
                        wr_data_d = req0_data_i;
                    end else begin
                        wr_en_d = 1'b0;
                    end
                end else if (req1_ready_o) begin
`ifdef REGFILE_ARB_RR_EN
                    rr_last_d = 1'b1;
`endif
                    if (req1_addr_i != ADDR_ZERO) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = req1_addr_i;
                        wr_data_d = req1_data_i;
                    end else begin
                        wr_en_d = 1'b0;
                    end
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                // clr_start_i is deliberately ignored here.
                wr_en_d    = 1'b1;
                wr_addr_d  = clr_addr_q;
                wr_data_d  = DATA_ZERO;
                clr_addr_d = clr_addr_q + ADDR_ONE;
                if (clr_addr_q == ADDR_LAST) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    clr_addr_d = ADDR_ONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                clr_addr_d = ADDR_ONE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= ADDR_ONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= ADDR_ZERO;
            wr_data_q  <= DATA_ZERO;
`ifdef REGFILE_ARB_RR_EN
            rr_last_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef REGFILE_ARB_RR_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

    assign clr_busy_o   = busy_q;
    assign clr_done_o   = done_q;
    assign rf_wr_en_o   = wr_en_q;
    assign rf_rd_addr_o = wr_addr_q;
    assign rf_rd_data_o = wr_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Directed stimulus pushes each expected register-file write (address, data,
// cycle in which it must be visible) into a queue; an independent monitor
// pops and compares every time rf_wr_en_o is seen high. Readies, busy and done
// are compared directly against hand-computed values by the stimulus process.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req0_valid_i = 1'b0;
    logic [AW-1:0] req0_addr_i  = '0;
    logic [DW-1:0] req0_data_i  = '0;
    logic          req0_ready_o;
    logic          req1_valid_i = 1'b0;
    logic [AW-1:0] req1_addr_i  = '0;
    logic [DW-1:0] req1_data_i  = '0;
    logic          req1_ready_o;
    logic          clr_start_i  = 1'b0;
    logic          clr_busy_o;
    logic          clr_done_o;
    logic          rf_wr_en_o;
    logic [AW-1:0] rf_rd_addr_o;
    logic [DW-1:0] rf_rd_data_o;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    regfile_wr_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_addr_i  (req0_addr_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_addr_i  (req1_addr_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .clr_start_i  (clr_start_i),
        .clr_busy_o   (clr_busy_o),
        .clr_done_o   (clr_done_o),
        .rf_wr_en_o   (rf_wr_en_o),
        .rf_rd_addr_o (rf_rd_addr_o),
        .rf_rd_data_o (rf_rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compares every observed write against the scoreboard queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                chk("missed_write_addr", 64'(e.addr), 64'hFFFF);
            end
            if (rf_wr_en_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", 64'(rf_rd_addr_o), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 64'(rf_rd_addr_o), 64'(e.addr));
                    chk("write_data", 64'(rf_rd_data_o), 64'(e.data));
                    chk("write_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    // Clear sequence: k is the cycle index relative to the clr_start_i pulse.
    task automatic run_clear(input bit with_req, input int restart_k, input int reset_k);
        bit exp_r0;
        for (int k = 0; k <= 33; k++) begin
            next_cycle();
            clr_start_i  = (k == 0) || (k == restart_k);
            req0_valid_i = with_req && (k <= 32);
            req0_addr_i  = 5'd11;
            req0_data_i  = 32'h0000_00A5;
            if (k == reset_k) begin
                #1;
                rst_i = 1'b1;
                exp_q.delete();
                #1;
                chk("rst_wr_en", 64'(rf_wr_en_o), 64'd0);
                chk("rst_addr", 64'(rf_rd_addr_o), 64'd0);
                chk("rst_data", 64'(rf_rd_data_o), 64'd0);
                chk("rst_busy", 64'(clr_busy_o), 64'd0);
                chk("rst_done", 64'(clr_done_o), 64'd0);
                break;
            end
            #3;
            exp_r0 = with_req && (k == 32);
            chk("clr_req0_ready", 64'(req0_ready_o), 64'(exp_r0));
            chk("clr_busy", 64'(clr_busy_o), 64'((k >= 1) && (k <= 31)));
            chk("clr_done", 64'(clr_done_o), 64'(k == 32));
            if (k >= 1 && k <= 31) push_exp(AW'(k), 32'd0);
            if (exp_r0) push_exp(5'd11, 32'h0000_00A5);
        end
        clr_start_i  = 1'b0;
        req0_valid_i = 1'b0;
    endtask

    initial begin
        bit exp_r1;
        int done_seen;

        // Reset state.
        #3;
        chk("reset_wr_en", 64'(rf_wr_en_o), 64'd0);
        chk("reset_addr", 64'(rf_rd_addr_o), 64'd0);
        chk("reset_data", 64'(rf_rd_data_o), 64'd0);
        chk("reset_busy", 64'(clr_busy_o), 64'd0);
        chk("reset_done", 64'(clr_done_o), 64'd0);
        next_cycle();
        next_cycle();
        rst_i = 1'b0;

        // Single write from req0.
        next_cycle();
        req0_valid_i = 1'b1; req0_addr_i = 5'd5; req0_data_i = 32'hDEAD_BEEF;
        #3;
        chk("single_req0_ready", 64'(req0_ready_o), 64'd1);
        chk("single_req1_ready", 64'(req1_ready_o), 64'd0);
        push_exp(5'd5, 32'hDEAD_BEEF);
        next_cycle();
        req0_valid_i = 1'b0;
        next_cycle();
        #3;
        chk("single_wr_en_low", 64'(rf_wr_en_o), 64'd0);

        // Write to x0 from req1 is accepted but dropped.
        next_cycle();
        req1_valid_i = 1'b1; req1_addr_i = 5'd0; req1_data_i = 32'h0000_1234;
        #3;
        chk("x0_req1_ready", 64'(req1_ready_o), 64'd1);
        chk("x0_req0_ready", 64'(req0_ready_o), 64'd0);
        next_cycle();
        req1_valid_i = 1'b0;
        #3;
        chk("x0_wr_en_c1", 64'(rf_wr_en_o), 64'd0);
        next_cycle();
        #3;
        chk("x0_wr_en_c2", 64'(rf_wr_en_o), 64'd0);

        // Contention: both valid for four cycles.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            req0_valid_i = 1'b1; req0_addr_i = 5'd3; req0_data_i = 32'h0000_0033;
            req1_valid_i = 1'b1; req1_addr_i = 5'd7; req1_data_i = 32'h0000_0077;
`ifdef REGFILE_ARB_RR_EN
            exp_r1 = (i % 2) == 1;
`else
            exp_r1 = 1'b0;
`endif
            #3;
            chk("tie_req0_ready", 64'(req0_ready_o), 64'(!exp_r1));
            chk("tie_req1_ready", 64'(req1_ready_o), 64'(exp_r1));
            if (exp_r1) push_exp(5'd7, 32'h0000_0077);
            else        push_exp(5'd3, 32'h0000_0033);
        end
        next_cycle();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        next_cycle();

        // Full clear with req0 waiting.
        run_clear(1'b1, -1, -1);
        next_cycle();
        next_cycle();

        // Second start at cycle 10 of a clear is ignored.
        run_clear(1'b0, 10, -1);
        next_cycle();
        next_cycle();

        // Asynchronous reset in the middle of a clear.
        run_clear(1'b0, -1, 15);
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        req0_valid_i = 1'b1; req0_addr_i = 5'd9; req0_data_i = 32'h0000_0099;
        #3;
        chk("post_rst_req0_ready", 64'(req0_ready_o), 64'd1);
        push_exp(5'd9, 32'h0000_0099);
        next_cycle();
        req0_valid_i = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 34; i++) begin
            #3;
            if (clr_done_o !== 1'b0 || clr_busy_o !== 1'b0) done_seen++;
            next_cycle();
        end
        chk("post_rst_no_done_busy", 64'(done_seen), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
